// File: rtl/mul_shared_pkg.sv
// Shared constants and types for the two-port shift-add multiplier.
package mul_shared_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

endpackage

// File: rtl/mul_core.sv
// Shift-add datapath: one multiplier bit per cycle, LSB first, after a load.
module mul_core
   import mul_shared_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   p_o
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic             running;
   logic [PW-1:0]    sum;
   logic             last;

   // Sum including the current step's add, so completion needs no extra cycle.
   assign sum    = acc + (mplier[0] ? mcand : '0);
   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign busy_o = running;
   assign done_o = running & last;
   assign p_o    = sum;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (load_i) begin
         acc     <= '0;
         mcand   <= PW'(a_i);
         mplier  <= b_i;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc     <= sum;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt + CNT_W'(1);
         if (last) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mul_shared.sv
// Two requester ports sharing one sequential multiplier, round-robin arbitrated.
module mul_shared
   import mul_shared_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WIDTH-1:0]     a0_i,
   input  logic [WIDTH-1:0]     b0_i,
   input  logic                 start0_i,
   output logic                 busy0_o,
   output logic [2*WIDTH-1:0]   y0_bo,
   input  logic [WIDTH-1:0]     a1_i,
   input  logic [WIDTH-1:0]     b1_i,
   input  logic                 start1_i,
   output logic                 busy1_o,
   output logic [2*WIDTH-1:0]   y1_bo
);

   state_t             state;
   state_t             state_d;
   logic               grant;
   logic               grant_d;
   logic               last_grant;
   logic               last_grant_d;
   logic               load_c;
   logic               complete_c;
   logic [1:0]         pend;
   logic [1:0]         start;
   logic [WIDTH-1:0]   a_in [2];
   logic [WIDTH-1:0]   b_in [2];
   logic [WIDTH-1:0]   a_q  [2];
   logic [WIDTH-1:0]   b_q  [2];
   logic [2*WIDTH-1:0] y_q  [2];
   logic               core_busy;
   logic               core_done;
   logic [2*WIDTH-1:0] core_p;

   assign start   = {start1_i, start0_i};
   assign a_in[0] = a0_i;
   assign a_in[1] = a1_i;
   assign b_in[0] = b0_i;
   assign b_in[1] = b1_i;

   assign busy0_o = pend[0];
   assign busy1_o = pend[1];
   assign y0_bo   = y_q[0];
   assign y1_bo   = y_q[1];

   // Capture, pending flags and held results; a busy port ignores start.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend <= '0;
         for (int n = 0; n < 2; n++) begin
            a_q[n] <= '0;
            b_q[n] <= '0;
            y_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (complete_c && (grant == 1'(n))) begin
               pend[n] <= 1'b0;
               y_q[n]  <= core_p;
            end else if (start[n] && !pend[n]) begin
               pend[n] <= 1'b1;
               a_q[n]  <= a_in[n];
               b_q[n]  <= b_in[n];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         grant      <= P0;
         last_grant <= P1;
      end else begin
         state      <= state_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
      end
   end

   // Arbiter and sequencing; on a tie the port that did not go last wins.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      load_c       = 1'b0;
      complete_c   = 1'b0;
      case (state)
         IDLE: begin
            if (|pend) begin
               if (&pend) begin
                  grant_d = ~last_grant;
               end else begin
                  grant_d = pend[1] ? P1 : P0;
               end
               last_grant_d = grant_d;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            load_c  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (core_busy && core_done) begin
               complete_c = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   mul_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load_c),
      .a_i    (a_q[grant]),
      .b_i    (b_q[grant]),
      .busy_o (core_busy),
      .done_o (core_done),
      .p_o    (core_p)
   );

endmodule

// File: tb/tb_mul_shared.sv
// Directed bench for mul_shared: timing, arbitration, ignore-while-busy, reset.
module tb_mul_shared;

   logic        clk_i;
   logic        rst_i;
   logic [7:0]  a0_i, b0_i, a1_i, b1_i;
   logic        start0_i, start1_i;
   logic        busy0_o, busy1_o;
   logic [15:0] y0_bo, y1_bo;

   int n_tests;
   int n_fail;

   mul_shared dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .a0_i     (a0_i),
      .b0_i     (b0_i),
      .start0_i (start0_i),
      .busy0_o  (busy0_o),
      .y0_bo    (y0_bo),
      .a1_i     (a1_i),
      .b1_i     (b1_i),
      .start1_i (start1_i),
      .busy1_o  (busy1_o),
      .y1_bo    (y1_bo)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got %b want 0", busy0_o); end
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1_o); end
      n_tests++; if (y0_bo !== 16'd0) begin n_fail++; $display("FAIL reset_y0 got %0d want 0", y0_bo); end
      n_tests++; if (y1_bo !== 16'd0) begin n_fail++; $display("FAIL reset_y1 got %0d want 0", y1_bo); end
      rst_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_port0();
      a0_i = 8'd3; b0_i = 8'd5; start0_i = 1'b1;
      @(negedge clk_i);
      start0_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_tests++; if (busy0_o !== 1'b1) begin n_fail++; $display("FAIL p0_busy k=%0d got %b want 1", k, busy0_o); end
         n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL p0_busy1_idle k=%0d got %b want 0", k, busy1_o); end
         @(negedge clk_i);
      end
      n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL p0_busy_end got %b want 0", busy0_o); end
      n_tests++; if (y0_bo !== 16'd15) begin n_fail++; $display("FAIL p0_y got %0d want 15", y0_bo); end
   endtask

   task automatic test_port1();
      a1_i = 8'd255; b1_i = 8'd255; start1_i = 1'b1;
      @(negedge clk_i);
      start1_i = 1'b0;
      repeat (9) @(negedge clk_i);
      n_tests++; if (busy1_o !== 1'b1) begin n_fail++; $display("FAIL p1_busy_last got %b want 1", busy1_o); end
      @(negedge clk_i);
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL p1_busy_end got %b want 0", busy1_o); end
      n_tests++; if (y1_bo !== 16'd65025) begin n_fail++; $display("FAIL p1_max got %0d want 65025", y1_bo); end
      a1_i = 8'd0; b1_i = 8'd200; start1_i = 1'b1;
      @(negedge clk_i);
      start1_i = 1'b0;
      repeat (10) @(negedge clk_i);
      n_tests++; if (y1_bo !== 16'd0) begin n_fail++; $display("FAIL p1_zero got %0d want 0", y1_bo); end
      n_tests++; if (y0_bo !== 16'd15) begin n_fail++; $display("FAIL p1_y0_held got %0d want 15", y0_bo); end
   endtask

   task automatic test_contention();
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      a0_i = 8'd3;  b0_i = 8'd7;  start0_i = 1'b1;
      a1_i = 8'd12; b1_i = 8'd12; start1_i = 1'b1;
      @(negedge clk_i);
      start0_i = 1'b0; start1_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k == 10) begin
            n_tests++; if (y0_bo !== 16'd21) begin n_fail++; $display("FAIL tie_y0 got %0d want 21", y0_bo); end
            n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL tie_busy0_end got %b want 0", busy0_o); end
            n_tests++; if (y1_bo !== 16'd0) begin n_fail++; $display("FAIL tie_y1_early got %0d want 0", y1_bo); end
         end
         n_tests++; if (busy1_o !== 1'b1) begin n_fail++; $display("FAIL tie_busy1 k=%0d got %b want 1", k, busy1_o); end
         @(negedge clk_i);
      end
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL tie_busy1_end got %b want 0", busy1_o); end
      n_tests++; if (y1_bo !== 16'd144) begin n_fail++; $display("FAIL tie_y1 got %0d want 144", y1_bo); end
   endtask

   task automatic test_ignore_busy();
      a0_i = 8'd2; b0_i = 8'd3; start0_i = 1'b1;
      @(negedge clk_i);
      a0_i = 8'd9; b0_i = 8'd9;
      @(negedge clk_i);
      start0_i = 1'b0;
      repeat (9) @(negedge clk_i);
      n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL ign_busy_end got %b want 0", busy0_o); end
      n_tests++; if (y0_bo !== 16'd6) begin n_fail++; $display("FAIL ign_y0 got %0d want 6", y0_bo); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL ign_no_extra k=%0d got %b want 0", k, busy0_o); end
      end
   endtask

   task automatic test_back_to_back();
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      a1_i = 8'd5; b1_i = 8'd6; start1_i = 1'b1;
      @(negedge clk_i);
      start1_i = 1'b0;
      repeat (10) @(negedge clk_i);
      n_tests++; if (y1_bo !== 16'd30) begin n_fail++; $display("FAIL b2b_first got %0d want 30", y1_bo); end
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL b2b_first_busy got %b want 0", busy1_o); end
      a0_i = 8'd7;  b0_i = 8'd8;  start0_i = 1'b1;
      a1_i = 8'd10; b1_i = 8'd11; start1_i = 1'b1;
      @(negedge clk_i);
      start0_i = 1'b0; start1_i = 1'b0;
      repeat (10) @(negedge clk_i);
      n_tests++; if (y0_bo !== 16'd56) begin n_fail++; $display("FAIL b2b_p0_first got %0d want 56", y0_bo); end
      n_tests++; if (y1_bo !== 16'd30) begin n_fail++; $display("FAIL b2b_p1_held got %0d want 30", y1_bo); end
      n_tests++; if (busy1_o !== 1'b1) begin n_fail++; $display("FAIL b2b_p1_waiting got %b want 1", busy1_o); end
      repeat (10) @(negedge clk_i);
      n_tests++; if (y1_bo !== 16'd110) begin n_fail++; $display("FAIL b2b_p1_second got %0d want 110", y1_bo); end
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL b2b_p1_busy_end got %b want 0", busy1_o); end
   endtask

   task automatic test_reset_mid();
      a0_i = 8'd13; b0_i = 8'd13; start0_i = 1'b1;
      @(negedge clk_i);
      start0_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy0 got %b want 0", busy0_o); end
      n_tests++; if (busy1_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy1 got %b want 0", busy1_o); end
      n_tests++; if (y0_bo !== 16'd0) begin n_fail++; $display("FAIL rmid_y0 got %0d want 0", y0_bo); end
      n_tests++; if (y1_bo !== 16'd0) begin n_fail++; $display("FAIL rmid_y1 got %0d want 0", y1_bo); end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      a0_i = 8'd6; b0_i = 8'd7; start0_i = 1'b1;
      @(negedge clk_i);
      start0_i = 1'b0;
      repeat (10) @(negedge clk_i);
      n_tests++; if (y0_bo !== 16'd42) begin n_fail++; $display("FAIL rmid_after got %0d want 42", y0_bo); end
      n_tests++; if (busy0_o !== 1'b0) begin n_fail++; $display("FAIL rmid_after_busy got %b want 0", busy0_o); end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst_i    = 1'b0;
      start0_i = 1'b0;
      start1_i = 1'b0;
      a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
      test_reset();
      test_port0();
      test_port1();
      test_contention();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_shared.md
Name: mul_shared

Overview:
- Sequential shift-add multiplier that is the upstream producer of the mul_a/mul_b/mul_start_i/mul_busy_o/mul_y_bo products consumed by cbrt.
- Two requester ports share one datapath:
  - port 0 is wired to cbrt;
  - port 1 is wired to the neighbouring square/scale stage.
- Round-robin arbitration between the ports.
- Each port has a per-port busy flag and a held result register.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 4, iteration counter width; must hold the value WIDTH.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- a0_i  in  WIDTH  port 0 multiplicand
- b0_i  in  WIDTH  port 0 multiplier
- start0_i  in  1  port 0 request pulse
- busy0_o  out  1  port 0 operation pending or in progress
- y0_bo  out  2*WIDTH  port 0 product, held
- a1_i, b1_i, start1_i, busy1_o, y1_bo  same as port 0, for port 1

Behaviour:
- Reset (rst_i low, asynchronous):
  - busy0_o=0, busy1_o=0, y0_bo=0, y1_bo=0;
  - core state=IDLE, pending flags=0, last_grant=1 (so port 0 wins the first tie).
- Request capture: at a rising edge with startN_i=1 and busyN_o=0:
  - latch aN_i/bN_i into the port operand registers;
  - set pendN; busyN_o reads 1 from the next cycle.
- startN_i while busyN_o=1 is ignored. Operands are not re-latched and no second request is queued.
- Core FSM states: IDLE, LOAD, RUN.
  - IDLE: if any pend flag is set, grant the port and go to LOAD.
    - Only one pending: that port is granted.
    - Both pending: grant the port != last_grant.
    - Record the granted port in last_grant.
  - LOAD: copy the granted port's operands into the core.
    - acc=0, mcand=a zero-extended to 2*WIDTH, mplier=b, cnt=0. Go to RUN.
  - RUN: one multiplier bit per cycle, LSB first.
    - If mplier[0]=1: acc += mcand.
    - mcand <<= 1, mplier >>= 1, cnt += 1.
    - On the step where cnt==WIDTH-1, complete the operation:
      - write the final acc (including this step's add) to yG_bo;
      - clear pendG and busyG_o in the same edge;
      - go to IDLE.
- Latency, uncontended request sampled at edge T:
  - grant at T+1, LOAD at T+2, RUN steps at T+3..T+10;
  - yN_bo valid and busyN_o=0 after edge T+10;
  - busy is high for 10 cycles.
- Consumer compatibility: busyN_o is 1 on the cycle after start is sampled. A consumer polling busy two cycles after start therefore never sees a stale 0.
- Contention: a losing port's request stays pending with busy=1. It is granted on the IDLE cycle directly after the winner completes, so there is no starvation.
- Simultaneous events:
  - A request arriving on the edge where the other port completes is captured normally.
  - A port may issue a new start on the first cycle its busy reads 0.
- Arithmetic:
  - unsigned;
  - acc is 2*WIDTH bits wide; the maximum product (2^WIDTH-1)^2 fits, so no overflow handling is needed.
- yN_bo holds its value until that port's next completion; it is never modified by the other port's operations.
- Reset mid-operation: everything returns to reset values immediately. The interrupted result is discarded and y registers are cleared.

Decomposition:
- Package mul_shared_pkg:
  - WIDTH default;
  - FSM state encodings (IDLE, LOAD, RUN) as a 2-bit typedef;
  - port index constants P0=0, P1=1.
- One sub-module, mul_core: LOAD/RUN datapath (acc, mcand, mplier, cnt) with load_i, busy_o, done_o, p_o.
- The top holds capture registers, pending/busy flags, arbiter and result registers.

Test Plan:
- Port 0 only, a0=3, b0=5, start0 one cycle at edge T -> busy0_o=1 from T+1 through T+10; y0_bo=15 after T+10; busy1_o stays 0.
- Port 1, a1=255, b1=255 -> y1_bo=65025; then a1=0, b1=200 -> y1_bo=0; y0_bo unchanged throughout.
- Both starts on the same edge (a0=3,b0=7; a1=12,b1=12) after reset:
  - port 0 served first: y0_bo=21 after T+10;
  - port 1: y1_bo=144 after T+20;
  - busy1_o held 1 for the whole interval.
- start0_i reasserted with new operands (9,9) while busy0_o=1 -> ignored; the result is the original product; no extra operation runs.
- Back-to-back: port 1 served once, then both request together -> port 0 granted (last_grant=1), then port 1.
- rst_i driven low at T+5 of an operation -> all busy and y outputs 0 immediately; after release, a new request (6,7) -> 42.
